// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding, the
// statistics counter width and a saturating-increment helper.
// Optional feature macro (used by fifo_wr_arbiter): FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int                    STAT_WIDTH = 16;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX   = 16'hFFFF;

    // Increment a beat counter, sticking at its maximum value
    function automatic logic [STAT_WIDTH-1:0] stat_sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == STAT_MAX) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotated-priority finder: returns the first requester with
// its request set, scanning i_last+1, i_last+2, ... modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [IDX_W-1:0] o_winner
);

    logic [IDX_W-1:0] w_idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx    = IDX_W'((int'(i_last) + k) % N_REQ);
            o_found  = o_found | i_req[w_idx];
            o_winner = i_req[w_idx] ? w_idx : o_winner;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// An owner keeps the port for up to MAX_BURST beats; the datapath from the
// selected requester to the FIFO is combinational (zero added latency).
// Optional per-requester beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ack,
    output logic [N_REQ-1:0]              gnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_ready,
    output logic [N_REQ*STAT_WIDTH-1:0]   stat_cnt
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_e       r_state,      w_nxt_state;
    logic [IDX_W-1:0] r_owner,      w_nxt_owner;
    logic [IDX_W-1:0] r_last_owner, w_nxt_last;
    logic [CNT_W-1:0] r_beat_cnt,   w_nxt_cnt;

    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_sel;
    logic             w_xfer;
    logic [N_REQ-1:0] w_gnt;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (req_vld),
        .i_last   (r_last_owner),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    // State register: FSM state, burst owner, rotation pointer and beat count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= LAST_RST;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_owner      <= w_nxt_owner;
            r_last_owner <= w_nxt_last;
            r_beat_cnt   <= w_nxt_cnt;
        end
    end

    // Next-state logic: start, extend, stall or end a burst
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_owner = r_owner;
        w_nxt_last  = r_last_owner;
        w_nxt_cnt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_found && wr_ready) begin
                    if (MAX_BURST == 1) begin
                        w_nxt_state = IDLE;
                        w_nxt_last  = w_winner;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_state = BURST;
                        w_nxt_owner = w_winner;
                        w_nxt_cnt   = CNT_W'(1);
                    end
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            BURST: begin
                if (req_vld[r_owner]) begin
                    if (wr_ready) begin
                        if ((r_beat_cnt + CNT_W'(1)) == CNT_MAX) begin
                            w_nxt_state = IDLE;
                            w_nxt_last  = r_owner;
                            w_nxt_cnt   = '0;
                        end else begin
                            w_nxt_cnt   = r_beat_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_nxt_cnt = r_beat_cnt;
                    end
                end else begin
                    // Owner went quiet: give up the port, costing one idle cycle
                    w_nxt_state = IDLE;
                    w_nxt_last  = r_owner;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_last  = LAST_RST;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Output decode: who is selected, whether a beat moves, and the grant vector
    always_comb begin
        w_sel  = r_owner;
        w_xfer = 1'b0;
        w_gnt  = '0;
        case (r_state)
            IDLE: begin
                w_sel  = w_winner;
                w_xfer = w_found & wr_ready;
                w_gnt  = w_xfer ? (ONE_HOT0 << w_winner) : '0;
            end
            BURST: begin
                w_sel  = r_owner;
                w_xfer = req_vld[r_owner] & wr_ready;
                w_gnt  = ONE_HOT0 << r_owner;
            end
            default: begin
                w_sel  = r_owner;
                w_xfer = 1'b0;
                w_gnt  = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even mid-burst
    assign wr_en   = w_xfer & reset;
    assign gnt     = reset ? w_gnt : '0;
    assign req_ack = wr_en ? (ONE_HOT0 << w_sel) : '0;
    assign wr_data = wr_en ? req_data[w_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat [N_REQ];

    // Per-requester saturating count of accepted beats, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                r_stat[i] <= req_ack[i] ? stat_sat_inc(r_stat[i]) : r_stat[i];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_cnt[g*STAT_WIDTH +: STAT_WIDTH] = r_stat[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
